// File: rtl/branch_resolve_unit_if.sv
// Instruction/flag bundle between the issue stage and branch_resolve_unit.
// The master side issues instructions; the slave side resolves branches.
interface branch_resolve_unit_if #(
    parameter int ADDR_W = 32
);
    logic              valid_i;
    logic [1:0]        opType_i;
    logic [3:0]        opCode_i;
    logic [ADDR_W-1:0] pc_i;
    logic [ADDR_W-1:0] offset_i;
    logic [1:0]        flags_i;
    logic              cmp_issue_i;
    logic              stall_o;
    logic              flush_o;
    logic              redirect_valid_o;
    logic [ADDR_W-1:0] redirect_pc_o;
    logic              taken_o;
    logic              resolved_o;
    logic [15:0]       taken_count_o;
    logic [15:0]       branch_count_o;

    modport master (
        output valid_i, opType_i, opCode_i, pc_i, offset_i, flags_i, cmp_issue_i,
        input  stall_o, flush_o, redirect_valid_o, redirect_pc_o, taken_o,
               resolved_o, taken_count_o, branch_count_o
    );

    modport slave (
        input  valid_i, opType_i, opCode_i, pc_i, offset_i, flags_i, cmp_issue_i,
        output stall_o, flush_o, redirect_valid_o, redirect_pc_o, taken_o,
               resolved_o, taken_count_o, branch_count_o
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Conditional-branch resolver with compare-flag interlock, PC redirect and flush.
// Define BRANCH_STATS_EN to enable the saturating taken/resolved branch counters.
module branch_resolve_unit #(
    parameter int ADDR_W       = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int FLAG_LAT     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    branch_resolve_unit_if.slave bus
);

    localparam int CNT_W  = (FLAG_LAT > 1) ? $clog2(FLAG_LAT + 1) : 1;
    localparam int FC_W   = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    // The issue cycle itself is covered by cmp_issue_i, so the counter only spans the remaining cycles.
    localparam int LOAD_V = (FLAG_LAT > 0) ? (FLAG_LAT - 1) : 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    function automatic logic is_branch_op(input logic [3:0] op);
        logic r;
        case (op)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5: r = 1'b1;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic branch_taken(input logic [3:0] op, input logic [1:0] flags);
        logic r;
        case (op)
            4'd0:    r = 1'b1;
            4'd1:    r = flags[0];
            4'd2:    r = !flags[0];
            4'd3:    r = flags[1];
            4'd4:    r = !flags[1];
            4'd5:    r = !flags[1] && !flags[0];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [FC_W-1:0]   fcnt_q;
    logic [3:0]        op_q;
    logic [ADDR_W-1:0] pc_q, off_q;
    logic              flush_q, redirect_valid_q, taken_q, resolved_q;
    logic [ADDR_W-1:0] redirect_pc_q;

    logic              hazard_s, is_br_s, capture_s, resolve_s, taken_s, stall_s;
    logic [3:0]        res_op_s;
    logic [ADDR_W-1:0] res_pc_s, res_off_s, target_s;

    // Hazard counter next state: a compare reloads it, otherwise it drains to zero
    always_comb begin
        cnt_d = cnt_q;
        if (FLAG_LAT == 0) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (bus.cmp_issue_i) begin
            cnt_d = CNT_W'(LOAD_V);
        end else if (cnt_q != {CNT_W{1'b0}}) begin
            cnt_d = cnt_q - CNT_W'(1'b1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Hazard counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hazard_s  = (FLAG_LAT != 0) && (bus.cmp_issue_i || (cnt_q != {CNT_W{1'b0}}));
    assign is_br_s   = bus.valid_i && (bus.opType_i == 2'b10) && is_branch_op(bus.opCode_i);
    assign capture_s = (state_q == ST_IDLE) && is_br_s && hazard_s;
    assign resolve_s = ((state_q == ST_IDLE) && is_br_s && !hazard_s) ||
                       ((state_q == ST_WAIT) && !hazard_s);

    assign res_op_s  = (state_q == ST_WAIT) ? op_q  : bus.opCode_i;
    assign res_pc_s  = (state_q == ST_WAIT) ? pc_q  : bus.pc_i;
    assign res_off_s = (state_q == ST_WAIT) ? off_q : bus.offset_i;
    assign taken_s   = branch_taken(res_op_s, bus.flags_i);
    assign target_s  = res_pc_s + res_off_s;

    // Stall is combinational so the issue stage holds the branch in the cycle it is parked
    always_comb begin
        stall_s = 1'b0;
        case (state_q)
            ST_IDLE:  stall_s = is_br_s && hazard_s;
            ST_WAIT:  stall_s = hazard_s;
            ST_FLUSH: stall_s = 1'b1;
            default:  stall_s = 1'b0;
        endcase
    end

    // Resolution FSM with registered one-cycle result pulses and flush window
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= ST_IDLE;
            fcnt_q           <= {FC_W{1'b0}};
            op_q             <= 4'h0;
            pc_q             <= {ADDR_W{1'b0}};
            off_q            <= {ADDR_W{1'b0}};
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            taken_q          <= 1'b0;
            resolved_q       <= 1'b0;
            redirect_pc_q    <= {ADDR_W{1'b0}};
        end else begin
            redirect_valid_q <= 1'b0;
            taken_q          <= 1'b0;
            resolved_q       <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (capture_s) begin
                        op_q    <= bus.opCode_i;
                        pc_q    <= bus.pc_i;
                        off_q   <= bus.offset_i;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: state_q <= ST_WAIT;
                ST_FLUSH: begin
                    if (fcnt_q == {FC_W{1'b0}}) begin
                        state_q <= ST_IDLE;
                        flush_q <= 1'b0;
                    end else begin
                        fcnt_q <= fcnt_q - FC_W'(1'b1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            if (resolve_s) begin
                resolved_q <= 1'b1;
                if (taken_s) begin
                    redirect_valid_q <= 1'b1;
                    taken_q          <= 1'b1;
                    redirect_pc_q    <= target_s;
                    flush_q          <= 1'b1;
                    fcnt_q           <= FC_W'(FLUSH_CYCLES - 1);
                    state_q          <= ST_FLUSH;
                end else begin
                    state_q <= ST_IDLE;
                end
            end
        end
    end

    assign bus.stall_o          = stall_s;
    assign bus.flush_o          = flush_q;
    assign bus.redirect_valid_o = redirect_valid_q;
    assign bus.redirect_pc_o    = redirect_pc_q;
    assign bus.taken_o          = taken_q;
    assign bus.resolved_o       = resolved_q;

`ifdef BRANCH_STATS_EN
    logic [15:0] taken_cnt_q, branch_cnt_q;

    // Saturating counters, updated on the same edge that raises the result pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            taken_cnt_q  <= 16'h0000;
            branch_cnt_q <= 16'h0000;
        end else begin
            if (resolve_s && (branch_cnt_q != 16'hFFFF)) begin
                branch_cnt_q <= branch_cnt_q + 16'd1;
            end
            if (resolve_s && taken_s && (taken_cnt_q != 16'hFFFF)) begin
                taken_cnt_q <= taken_cnt_q + 16'd1;
            end
        end
    end

    assign bus.taken_count_o  = taken_cnt_q;
    assign bus.branch_count_o = branch_cnt_q;
`else
    assign bus.taken_count_o  = 16'h0000;
    assign bus.branch_count_o = 16'h0000;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: vector table, corner sequences
// and randomized traffic against a cycle-level reference model.
module tb_branch_resolve_unit;
    localparam int AW = 32;
    localparam int FC = 2;
    localparam int FL = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_resolve_unit_if #(.ADDR_W(AW)) bus ();

    branch_resolve_unit #(.ADDR_W(AW), .FLUSH_CYCLES(FC), .FLAG_LAT(FL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state: the flag-ready time is tracked as the cycle of the last compare.
    int          cyc, last_cmp, flush_left;
    bit          pend;
    logic [3:0]  pend_op;
    logic [31:0] pend_pc, pend_off;
    bit          e_res, e_tk, e_stall;
    logic [31:0] e_pc;
    int          e_tc, e_bc;
    logic        last_stall;

    typedef struct {
        logic [1:0]  ty;
        logic [3:0]  op;
        logic [31:0] pc;
        logic [31:0] off;
        logic [1:0]  fl;
        logic        e_res;
        logic        e_tk;
        logic [31:0] e_pc;
    } vec_t;
    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic bit cond(input logic [3:0] op, input logic [1:0] fl);
        bit z, n;
        z = fl[0];
        n = fl[1];
        case (op)
            4'd0: return 1'b1;      // B
            4'd1: return z;         // BEQ
            4'd2: return !z;        // BNE
            4'd3: return n;         // BLT
            4'd4: return !n;        // BGE
            4'd5: return !n && !z;  // BGT
            default: return 1'b0;
        endcase
    endfunction

    task automatic reset_model();
        cyc = 0; last_cmp = -1000; flush_left = 0; pend = 0;
        e_res = 0; e_tk = 0; e_pc = 32'h0; e_tc = 0; e_bc = 0;
    endtask

    task automatic drive_idle();
        bus.valid_i = 1'b0; bus.opType_i = 2'b00; bus.opCode_i = 4'h0;
        bus.pc_i = 32'h0; bus.offset_i = 32'h0; bus.flags_i = 2'b00; bus.cmp_issue_i = 1'b0;
    endtask

    task automatic check_outputs();
        chk("resolved", bus.resolved_o, e_res);
        chk("taken", bus.taken_o, e_tk);
        chk("redirect_valid", bus.redirect_valid_o, e_tk);
        chk("flush", bus.flush_o, flush_left > 0);
        if (e_tk) chk("redirect_pc", bus.redirect_pc_o, e_pc);
`ifdef BRANCH_STATS_EN
        chk("taken_count", bus.taken_count_o, e_tc);
        chk("branch_count", bus.branch_count_o, e_bc);
`else
        chk("taken_count", bus.taken_count_o, 32'h0);
        chk("branch_count", bus.branch_count_o, 32'h0);
`endif
    endtask

    // One clock: drive inputs, predict, check stall mid-cycle and registered results after the edge.
    task automatic step(input logic v, input logic [1:0] ty, input logic [3:0] op,
                        input logic [31:0] pc, input logic [31:0] off,
                        input logic [1:0] fl, input logic cmp);
        bit isbr, haz, tk;
        logic [3:0] bop;
        logic [31:0] bpc, boff;
        bus.valid_i = v; bus.opType_i = ty; bus.opCode_i = op; bus.pc_i = pc;
        bus.offset_i = off; bus.flags_i = fl; bus.cmp_issue_i = cmp;
        isbr = v && (ty == 2'b10) && (op <= 4'd5);
        haz  = (FL > 0) && (cmp || ((cyc - last_cmp) < FL));
        if (flush_left > 0) e_stall = 1;
        else if (pend)      e_stall = haz;
        else                e_stall = isbr && haz;
        e_res = 0; e_tk = 0;
        if (flush_left > 0) begin
            flush_left--;
        end else if (pend || isbr) begin
            bop  = pend ? pend_op  : op;
            bpc  = pend ? pend_pc  : pc;
            boff = pend ? pend_off : off;
            if (haz) begin
                pend = 1; pend_op = bop; pend_pc = bpc; pend_off = boff;
            end else begin
                pend = 0; e_res = 1;
                tk = cond(bop, fl);
                e_tk = tk;
                if (e_bc < 65535) e_bc++;
                if (tk) begin
                    e_pc = bpc + boff;
                    flush_left = FC;
                    if (e_tc < 65535) e_tc++;
                end
            end
        end
        if (cmp) last_cmp = cyc;
        @(negedge clk);
        last_stall = bus.stall_o;
        chk("stall", bus.stall_o, e_stall);
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 2'b00, 4'h0, 32'h0, 32'h0, 2'b00, 1'b0);
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b0;
        #1;
        chk("rst_flush", bus.flush_o, 1'b0);
        chk("rst_redirect_valid", bus.redirect_valid_o, 1'b0);
        chk("rst_resolved", bus.resolved_o, 1'b0);
        chk("rst_taken", bus.taken_o, 1'b0);
        chk("rst_stall", bus.stall_o, 1'b0);
        chk("rst_redirect_pc", bus.redirect_pc_o, 32'h0);
        chk("rst_branch_count", bus.branch_count_o, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        reset_model();
    endtask

    initial begin
        vecs[0] = '{2'b10, 4'd1, 32'h0000_0100, 32'h0000_0020, 2'b01, 1'b1, 1'b1, 32'h0000_0120};
        vecs[1] = '{2'b10, 4'd3, 32'h0000_0200, 32'h0000_0010, 2'b00, 1'b1, 1'b0, 32'h0};
        vecs[2] = '{2'b10, 4'd2, 32'h0000_0300, 32'h0000_0008, 2'b00, 1'b1, 1'b1, 32'h0000_0308};
        vecs[3] = '{2'b10, 4'd0, 32'hFFFF_FFF0, 32'h0000_0020, 2'b00, 1'b1, 1'b1, 32'h0000_0010};
        vecs[4] = '{2'b10, 4'd4, 32'h0000_0100, 32'hFFFF_FFF0, 2'b00, 1'b1, 1'b1, 32'h0000_00F0};
        vecs[5] = '{2'b10, 4'd5, 32'h0000_0400, 32'h0000_0004, 2'b01, 1'b1, 1'b0, 32'h0};
        vecs[6] = '{2'b01, 4'd0, 32'h0000_0500, 32'h0000_0004, 2'b00, 1'b0, 1'b0, 32'h0};
        vecs[7] = '{2'b10, 4'd6, 32'h0000_0600, 32'h0000_0004, 2'b00, 1'b0, 1'b0, 32'h0};
        vecs[8] = '{2'b10, 4'd4, 32'h0000_0700, 32'h0000_0004, 2'b10, 1'b1, 1'b0, 32'h0};
        vecs[9] = '{2'b10, 4'd3, 32'h0000_0800, 32'h0000_0040, 2'b10, 1'b1, 1'b1, 32'h0000_0840};

        drive_idle();
        rst = 1'b0;
        #12;
        do_reset();

        for (int i = 0; i < 10; i++) begin
            step(1'b1, vecs[i].ty, vecs[i].op, vecs[i].pc, vecs[i].off, vecs[i].fl, 1'b0);
            chk("vec_resolved", bus.resolved_o, vecs[i].e_res);
            chk("vec_taken", bus.taken_o, vecs[i].e_tk);
            if (vecs[i].e_tk) chk("vec_target", bus.redirect_pc_o, vecs[i].e_pc);
            idle(3);
        end

        // Back-to-back not-taken BLT then taken BNE, no stall between them
        step(1'b1, 2'b10, 4'd3, 32'h1000, 32'h10, 2'b00, 1'b0);
        chk("b2b_blt_nt", bus.taken_o, 1'b0);
        step(1'b1, 2'b10, 4'd2, 32'h1004, 32'h10, 2'b00, 1'b0);
        chk("b2b_bne_stall", last_stall, 1'b0);
        chk("b2b_bne_taken", bus.taken_o, 1'b1);
        idle(3);

        // Compare and BGT together: one stall cycle, then resolved with the new flags
        step(1'b1, 2'b10, 4'd5, 32'h200, 32'h40, 2'b11, 1'b1);
        chk("cmp_bgt_stall", last_stall, 1'b1);
        step(1'b1, 2'b10, 4'd5, 32'h200, 32'h40, 2'b00, 1'b0);
        chk("cmp_bgt_nostall", last_stall, 1'b0);
        chk("cmp_bgt_taken", bus.taken_o, 1'b1);
        chk("cmp_bgt_target", bus.redirect_pc_o, 32'h240);
        idle(3);

        // A second compare during the wait extends the stall
        step(1'b1, 2'b10, 4'd1, 32'h300, 32'h8, 2'b00, 1'b1);
        step(1'b1, 2'b10, 4'd1, 32'h300, 32'h8, 2'b00, 1'b1);
        chk("wait_ext_stall", last_stall, 1'b1);
        chk("wait_ext_nores", bus.resolved_o, 1'b0);
        step(1'b1, 2'b10, 4'd1, 32'h300, 32'h8, 2'b01, 1'b0);
        chk("wait_ext_taken", bus.taken_o, 1'b1);
        idle(3);

        // Reset in the middle of the flush window, then a normal BEQ
        step(1'b1, 2'b10, 4'd1, 32'h300, 32'h4, 2'b01, 1'b0);
        chk("pre_rst_flush", bus.flush_o, 1'b1);
        do_reset();
        step(1'b1, 2'b10, 4'd1, 32'h100, 32'h8, 2'b01, 1'b0);
        chk("post_rst_taken", bus.taken_o, 1'b1);
        chk("post_rst_target", bus.redirect_pc_o, 32'h108);
        idle(3);

        // Reset while a branch is parked: no redirect may follow
        step(1'b1, 2'b10, 4'd0, 32'h500, 32'h4, 2'b00, 1'b1);
        do_reset();
        idle(3);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b10,
                 4'($urandom_range(0, 7)), $urandom, $urandom,
                 2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
        end
        idle(4);

`ifdef BRANCH_STATS_EN
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2'b10, 4'd0, 32'h40, 32'h4, 2'b00, 1'b0);
            idle(3);
        end
        step(1'b1, 2'b10, 4'd1, 32'h40, 32'h4, 2'b00, 1'b0);
        step(1'b1, 2'b10, 4'd1, 32'h40, 32'h4, 2'b00, 1'b0);
        chk("stats_taken3", bus.taken_count_o, 32'd3);
        chk("stats_branch5", bus.branch_count_o, 32'd5);
        for (int i = 0; i < 65535; i++) step(1'b1, 2'b10, 4'd3, 32'h0, 32'h4, 2'b00, 1'b0);
        chk("stats_saturate", bus.branch_count_o, 32'hFFFF);
        chk("stats_taken_hold", bus.taken_count_o, 32'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
